// File: rtl/error_inject_sequencer.sv
// error_inject_sequencer: multi-channel address-matched fault injector on a monitored access stream
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   cfg_*                      ARM/DISARM requests with valid/ready handshake
//   acc_valid/addr/data        monitored access stream, no backpressure
//   out_valid/data/hit/ch      registered access result, one cycle latency
//   ch_busy, ch_done           per-channel status
//   done_pulse, inject_total   completion strobe and saturating injection counter
module error_inject_sequencer #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_CH = 4,
  parameter int CNT_WIDTH = 16,
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic                  cfg_op,
  input  logic [CHW-1:0]        cfg_ch,
  input  logic [1:0]            cfg_mode,
  input  logic [DATA_WIDTH-1:0] cfg_mask,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [ADDR_WIDTH-1:0] cfg_addr_mask,
  input  logic [CNT_WIDTH-1:0]  cfg_skip,
  input  logic [CNT_WIDTH-1:0]  cfg_count,
  input  logic                  acc_valid,
  input  logic [ADDR_WIDTH-1:0] acc_addr,
  input  logic [DATA_WIDTH-1:0] acc_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_hit,
  output logic [CHW-1:0]        out_ch,
  output logic [NUM_CH-1:0]     ch_busy,
  output logic [NUM_CH-1:0]     ch_done,
  output logic                  done_pulse,
  output logic [31:0]           inject_total
);
  typedef enum logic [1:0] {IDLE, SKIP, ACTIVE, DONE} st_e;
  st_e                   st_q [NUM_CH];
  st_e                   st_d [NUM_CH];
  logic [1:0]            mode_q [NUM_CH];
  logic [1:0]            mode_d [NUM_CH];
  logic [DATA_WIDTH-1:0] pat_q [NUM_CH];
  logic [DATA_WIDTH-1:0] pat_d [NUM_CH];
  logic [ADDR_WIDTH-1:0] addr_q [NUM_CH];
  logic [ADDR_WIDTH-1:0] addr_d [NUM_CH];
  logic [ADDR_WIDTH-1:0] amask_q [NUM_CH];
  logic [ADDR_WIDTH-1:0] amask_d [NUM_CH];
  logic [CNT_WIDTH-1:0]  skip_q [NUM_CH];
  logic [CNT_WIDTH-1:0]  skip_d [NUM_CH];
  logic [CNT_WIDTH-1:0]  cnt_q [NUM_CH];
  logic [CNT_WIDTH-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0]     done_q, done_d, match;
  logic                  hit, sel_busy;
  logic [CHW-1:0]        win;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  out_valid_q, out_valid_d, out_hit_q, out_hit_d, done_pulse_q, done_pulse_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [CHW-1:0]        out_ch_q, out_ch_d;
  logic [31:0]           total_q, total_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q         <= '{default: IDLE};
      mode_q       <= '{default: '0};
      pat_q        <= '{default: '0};
      addr_q       <= '{default: '0};
      amask_q      <= '{default: '0};
      skip_q       <= '{default: '0};
      cnt_q        <= '{default: '0};
      done_q       <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_hit_q    <= 1'b0;
      out_ch_q     <= '0;
      done_pulse_q <= 1'b0;
      total_q      <= '0;
    end else begin
      st_q         <= st_d;
      mode_q       <= mode_d;
      pat_q        <= pat_d;
      addr_q       <= addr_d;
      amask_q      <= amask_d;
      skip_q       <= skip_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_hit_q    <= out_hit_d;
      out_ch_q     <= out_ch_d;
      done_pulse_q <= done_pulse_d;
      total_q      <= total_d;
    end
  end

  // Descending scan so the lowest-index ACTIVE match is the last one written and wins.
  always_comb begin
    hit      = 1'b0;
    win      = '0;
    win_data = acc_data;
    sel_busy = 1'b0;
    ch_busy  = '0;
    match    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      ch_busy[i] = st_q[i] == SKIP || st_q[i] == ACTIVE;
      match[i]   = acc_valid && ch_busy[i] && ((acc_addr & amask_q[i]) == (addr_q[i] & amask_q[i]));
      if (match[i] && st_q[i] == ACTIVE) begin
        hit      = 1'b1;
        win      = CHW'(i);
        win_data = mode_q[i] == 2'd2 ? acc_data & ~pat_q[i] :
                   mode_q[i] == 2'd3 ? acc_data | pat_q[i] : acc_data ^ pat_q[i];
      end
      if (cfg_ch == CHW'(i) && ch_busy[i]) sel_busy = 1'b1;
    end
    cfg_ready = !rst_n || cfg_op || !sel_busy;
  end

  // Access effects are computed from the current state first; an accepted config then overrides them.
  always_comb begin
    done_pulse_d = 1'b0;
    done_d       = done_q;
    for (int i = 0; i < NUM_CH; i++) begin
      st_d[i]    = st_q[i];
      mode_d[i]  = mode_q[i];
      pat_d[i]   = pat_q[i];
      addr_d[i]  = addr_q[i];
      amask_d[i] = amask_q[i];
      skip_d[i]  = skip_q[i];
      cnt_d[i]   = cnt_q[i];
      if (match[i] && st_q[i] == SKIP) begin
        skip_d[i] = skip_q[i] - CNT_WIDTH'(1);
        if (skip_q[i] == CNT_WIDTH'(1)) st_d[i] = ACTIVE;
      end
      if (hit && win == CHW'(i)) begin
        if (mode_q[i] == 2'd1) pat_d[i] = {pat_q[i][DATA_WIDTH-2:0], pat_q[i][DATA_WIDTH-1]};
        if (cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - CNT_WIDTH'(1);
          if (cnt_q[i] == CNT_WIDTH'(1)) begin
            st_d[i]      = DONE;
            done_d[i]    = 1'b1;
            done_pulse_d = 1'b1;
          end
        end
      end
      if (cfg_valid && cfg_ready && cfg_ch == CHW'(i)) begin
        if (!cfg_op) begin
          st_d[i]    = cfg_skip != '0 ? SKIP : ACTIVE;
          mode_d[i]  = cfg_mode;
          pat_d[i]   = cfg_mask;
          addr_d[i]  = cfg_addr;
          amask_d[i] = cfg_addr_mask;
          skip_d[i]  = cfg_skip;
          cnt_d[i]   = cfg_count;
          done_d[i]  = 1'b0;
        end else if (st_q[i] != IDLE) begin
          st_d[i]   = IDLE;
          done_d[i] = 1'b0;
        end
      end
    end
    out_valid_d = acc_valid;
    out_data_d  = hit ? win_data : acc_data;
    out_hit_d   = hit;
    out_ch_d    = win;
    total_d     = hit && total_q != '1 ? total_q + 32'd1 : total_q;
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_hit      = out_hit_q;
  assign out_ch       = out_ch_q;
  assign ch_done      = done_q;
  assign done_pulse   = done_pulse_q;
  assign inject_total = total_q;
endmodule

// File: doc/error_inject_sequencer.md
ERROR_INJECT_SEQUENCER -- requirements
Module: error_inject_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, access data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, access address width.
REQ-003 SHALL have parameter NUM_CH, default 4, number of independent injection channels (1..16).
REQ-004 SHALL have parameter CNT_WIDTH, default 16, width of the skip and count fields.
REQ-005 clk  in  1  sole clock; all logic samples on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 cfg_valid  in  1  config request; cfg_ready  out  1  config accept; transfer when both high.
REQ-008 cfg_op  in  1  0=ARM, 1=DISARM; cfg_ch  in  max(1,$clog2(NUM_CH))  target channel.
REQ-009 cfg_mode  in  2  0=XOR fixed, 1=XOR rotating, 2=stuck-at-0, 3=stuck-at-1.
REQ-010 cfg_mask  in  DATA_WIDTH  error pattern; cfg_addr, cfg_addr_mask  in  ADDR_WIDTH  address match value/mask.
REQ-011 cfg_skip, cfg_count  in  CNT_WIDTH  matches to skip before first injection; injections to perform (0 = unlimited).
REQ-012 acc_valid  in  1; acc_addr  in  ADDR_WIDTH; acc_data  in  DATA_WIDTH  monitored access stream, no backpressure.
REQ-013 out_valid  out  1; out_data  out  DATA_WIDTH; out_hit  out  1; out_ch  out  max(1,$clog2(NUM_CH))  registered result.
REQ-014 ch_busy, ch_done  out  NUM_CH  per-channel status; done_pulse  out  1; inject_total  out  32.

Function
REQ-015 Per-channel FSM SHALL have states IDLE, SKIP, ACTIVE, DONE.
REQ-016 ARM accepted: channel loads all cfg_* fields, clears ch_done, enters SKIP if cfg_skip>0 else ACTIVE; rotating pattern register loads cfg_mask.
REQ-017 DISARM accepted: channel enters IDLE from any state, clears ch_done; DISARM of an IDLE channel is a no-op.
REQ-018 cfg_ready SHALL be low only when cfg_op=ARM and cfg_ch addresses a channel in SKIP or ACTIVE; DISARM always accepted; cfg_ch >= NUM_CH accepted and ignored.
REQ-019 Channel matches when acc_valid and (acc_addr & addr_mask) == (addr & addr_mask), evaluated in SKIP or ACTIVE only.
REQ-020 SKIP: each match decrements skip counter; match with counter==1 moves to ACTIVE; skipped accesses are never corrupted.
REQ-021 ACTIVE: among ACTIVE matching channels, lowest index wins; only the winner injects and consumes count; losers and SKIP channels are unaffected except REQ-020.
REQ-022 Winner with count==1 moves to DONE, sets ch_done (sticky), pulses done_pulse one cycle; count==0 at ARM means unlimited, never reaches DONE.
REQ-023 Corruption: XOR modes out=data^pattern; stuck-at-0 out=data&~mask; stuck-at-1 out=data|mask.
REQ-024 Rotating mode: pattern rotates left by 1 bit (MSB to bit 0) after each injection by that channel.
REQ-025 Latency exactly 1 cycle: out_valid=acc_valid, out_data=(corrupted or passthrough data), out_hit=1 iff injected, out_ch=winner index (0 if no hit), all registered.
REQ-026 inject_total increments once per injection, saturates at 0xFFFFFFFF.
REQ-027 ch_busy[i]=1 iff channel i in SKIP or ACTIVE.
REQ-028 Same-cycle config and access on one channel: access uses pre-config state; config effective next cycle.
REQ-029 Multiple channels reaching DONE in one cycle: done_pulse single cycle high.

Reset
REQ-030 rst_n low at a clock edge SHALL force all channels IDLE, counters and patterns 0, ch_done=0, inject_total=0, out_valid=0, out_hit=0, out_data=0, out_ch=0, done_pulse=0.
REQ-031 Reset mid-injection SHALL discard in-flight output; cfg_ready=1 during and after reset.

Verification
REQ-032 ARM ch0 mode0 mask=0x1 addr=0x100 mask=0xFFFFFFFF skip=0 count=2; four accesses 0x100 data=0 -> out_data 1,1,0,0; out_hit 1,1,0,0; ch_done[0]=1, done_pulse once, inject_total=2.
REQ-033 ARM ch1 skip=3 count=1 mode3 mask=0xF0; five matching accesses data=0 -> only 4th out_data=0xF0, ch1 DONE after it.
REQ-034 ARM ch0 and ch2 both ACTIVE on 0x200; access 0x200 -> out_ch=0, only ch0 count consumed; DISARM ch0; next access -> out_ch=2.
REQ-035 Mode1 mask=0x8000...0001, count=0; three hits data=0 -> 0x8000...0001, 0x0000...0003, 0x0000...0006; ch_busy stays 1.
REQ-036 ARM to busy ch -> cfg_ready=0; same-cycle DISARM+match -> access injected, channel IDLE next cycle; rst_n low mid-stream -> all outputs 0 next cycle.
